// File: rtl/dsc_serial_mul_if.sv
// Purpose: operand/result bundle for the deterministic stochastic-computing
// serial multiplier.
// Signals:
//   en  - clock enable; when low the multiplier holds all state
//   a   - unsigned operand A, held stable from reset release until ov
//   b   - unsigned operand B, held stable from reset release until ov
//   z   - 2*WIDTH-bit product, valid whenever ov is high
//   ov  - operation finished, sticky until reset
// Modports: master drives en/a/b and observes z/ov; slave is the multiplier.
interface dsc_serial_mul_if #(
  parameter int WIDTH = 8
);
  logic               en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] z;
  logic               ov;

  modport master (output en, a, b, input z, ov);
  modport slave  (input en, a, b, output z, ov);
endinterface

// File: rtl/dsc_serial_mul.sv
// Purpose: deterministic stochastic-computing unsigned multiplier. Operand A
// becomes a full-rate unary stream, operand B a stream that advances once per
// full A period (clock division). The ANDed streams are counted into z, and the
// run stops as soon as B's stream has no ones left, giving z = a*b exactly.
// Ports:
//   clk_i - clock, all state updates on the rising edge
//   rst_i - synchronous active-high reset
//   bus   - slave side of dsc_serial_mul_if (en, a, b in; z, ov out)

// Generic wrapping up-counter used for both stream counters.
// Ports: clk_i, rst_i (sync), en_i (count enable), out_o (current count),
// overflow_o (high in the enabled cycle that wraps all-ones back to zero).
module DscCounter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] out_o,
  output logic             overflow_o
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_o      = cnt_q;
  // Combinational so the next stage can advance on the very same edge as the wrap.
  assign overflow_o = en_i & (&cnt_q);
endmodule

module dsc_serial_mul #(
  parameter int WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dsc_serial_mul_if.slave bus
);
  logic [WIDTH-1:0]   ctrA;
  logic [WIDTH-1:0]   ctrB;
  logic               wrapA;
  logic               ctrBWrap_unused;
  logic               snA;
  logic               snB;
  logic               snMul;
  logic               term;
  logic               advance;
  logic [2*WIDTH-1:0] z_q;
  logic [2*WIDTH-1:0] z_d;
  logic               done_q;
  logic               done_d;

  assign snA   = bus.a > ctrA;
  assign snB   = bus.b > ctrB;
  assign snMul = snA & snB;

  // Once ctrB reaches b, stream B is all zeros from here on, so nothing more
  // can be accumulated; a==0 means stream A never produces a one.
  assign term    = (ctrB == bus.b) | (bus.a == '0);
  assign advance = bus.en & ~done_q & ~term;

  DscCounter #(.WIDTH(WIDTH)) uCtrA (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (advance),
    .out_o      (ctrA),
    .overflow_o (wrapA)
  );

  // ctrB stops at b and therefore never wraps; its overflow is left unused.
  DscCounter #(.WIDTH(WIDTH)) uCtrB (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (wrapA),
    .out_o      (ctrB),
    .overflow_o (ctrBWrap_unused)
  );

  always_comb begin
    z_d    = z_q;
    done_d = done_q;
    if (bus.en && !done_q) begin
      if (term) begin
        done_d = 1'b1;
      end else begin
        z_d = z_q + {{(2*WIDTH-1){1'b0}}, snMul};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      z_q    <= '0;
      done_q <= 1'b0;
    end else begin
      z_q    <= z_d;
      done_q <= done_d;
    end
  end

  assign bus.z  = z_q;
  assign bus.ov = done_q;
endmodule

// File: tb/tb_dsc_serial_mul.sv
// Purpose: self-checking bench for dsc_serial_mul. Expected products, partial
// counts and latencies come from plain arithmetic on the operands.
module tb_dsc_serial_mul;
  localparam int WIDTH  = 8;
  localparam int PERIOD = 1 << WIDTH;

  logic clk_i = 1'b0;
  logic rst_i;
  int   compared   = 0;
  int   mismatched = 0;

  dsc_serial_mul_if #(.WIDTH(WIDTH)) bus ();

  dsc_serial_mul #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Exact product of the two operands
  function automatic int modelProduct(int a, int b);
    return a * b;
  endfunction

  // Enabled cycles from the first enabled edge until ov is seen high
  function automatic int modelLatency(int a, int b);
    if (a == 0 || b == 0) return 1;
    return b * PERIOD + 1;
  endfunction

  // Count of ANDed ones after n accumulate cycles (n <= b*PERIOD): each full
  // A period adds a, the partial period adds min(column, a)
  function automatic int modelPartial(int a, int n);
    int col;
    col = n % PERIOD;
    return (n / PERIOD) * a + ((col < a) ? col : a);
  endfunction

  // Compare one observed value against its expected value
  task automatic checkOutput(string tag, int observed, int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reset with new operands, check the reset state, then release and enable
  task automatic applyStimulus(int a, int b);
    @(negedge clk_i);
    rst_i  = 1'b1;
    bus.en = 1'b0;
    bus.a  = WIDTH'(a);
    bus.b  = WIDTH'(b);
    @(negedge clk_i);
    checkOutput("reset_z", int'(bus.z), 0);
    checkOutput("reset_ov", int'(bus.ov), 0);
    rst_i  = 1'b0;
    bus.en = 1'b1;
  endtask

  // Let n enabled edges pass
  task automatic stepEnabled(int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Count edges until ov rises, giving up after maxCycles
  task automatic waitOv(int maxCycles, output int cycles);
    cycles = 0;
    while (!bus.ov && cycles < maxCycles) begin
      @(negedge clk_i);
      cycles++;
    end
  endtask

  // Full operation: reset, run to ov, check latency and product
  task automatic runOp(string tag, int a, int b);
    int cycles;
    applyStimulus(a, b);
    waitOv(modelLatency(a, b) + 10, cycles);
    checkOutput({tag, "_latency"}, cycles, modelLatency(a, b));
    checkOutput({tag, "_z"}, int'(bus.z), modelProduct(a, b));
  endtask

  initial begin
    int cycles;
    int ra;
    int rb;
    rst_i  = 1'b1;
    bus.en = 1'b0;
    bus.a  = '0;
    bus.b  = '0;

    // Small square, then ov must stay sticky and z frozen while en toggles
    runOp("a15b15", 15, 15);
    bus.en = 1'b0;
    stepEnabled(3);
    bus.en = 1'b1;
    stepEnabled(3);
    checkOutput("sticky_ov", int'(bus.ov), 1);
    checkOutput("sticky_z", int'(bus.z), 225);

    // Zero operands finish on the first enabled cycle
    runOp("a0b37", 0, 37);
    runOp("a200b0", 200, 0);

    // Largest operands: full run, no wrap
    runOp("a255b255", 255, 255);

    // Enable gap mid-run freezes z and ov
    applyStimulus(100, 3);
    stepEnabled(300);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepEnabled(10);
      checkOutput("gap_z", int'(bus.z), modelPartial(100, 300));
      checkOutput("gap_ov", int'(bus.ov), 0);
    end
    bus.en = 1'b1;
    waitOv(modelLatency(100, 3) + 10, cycles);
    checkOutput("gap_latency", cycles + 300, modelLatency(100, 3));
    checkOutput("gap_final_z", int'(bus.z), 300);

    // Reset mid-run aborts; the following run starts from zero
    applyStimulus(255, 10);
    stepEnabled(500);
    checkOutput("abort_partial_z", int'(bus.z), modelPartial(255, 500));
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abort_z", int'(bus.z), 0);
    checkOutput("abort_ov", int'(bus.ov), 0);
    runOp("a7b9", 7, 9);

    // Random back-to-back operations (b kept small to bound the run time)
    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 4));
      $display("[TB] random op %0d: a=%0d b=%0d", i, ra, rb);
      runOp("random", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dsc_serial_mul.md
# dsc_serial_mul

Deterministic stochastic-computing (DSC) unsigned multiplier with two inputs. It converts each binary operand to a unary bit-stream using the clock-division scheme: operand A's stream runs at full rate, and operand B's stream advances once per full A period. It ANDs the two streams and counts the ones into a binary result. The block stops early as soon as B's stream can contribute no more ones, so the result is exact (z = a*b) and available well before 2^(2·WIDTH) cycles for most inputs.

## Interface
- WIDTH, 8: operand width in bits. The result width is 2·WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when low, all state holds.
- a  in  WIDTH  unsigned operand A; must be held stable from reset release until ov.
- b  in  WIDTH  unsigned operand B; same stability rule as a.
- z  out  2·WIDTH  unsigned product, accumulated count of ANDed stream ones.
- ov  out  1  operation finished; sticky high until rst.

## Operation
- Internal state:
  - ctr_a (WIDTH-bit stream-A counter)
  - ctr_b (WIDTH-bit stream-B counter)
  - z accumulator (2·WIDTH bits)
  - done flag, which drives ov
- Implement ctr_a and ctr_b with a reusable generic counter submodule. Its ports are clk, rst, en, out, and overflow. overflow pulses when the counter wraps from all-ones to 0.
- Stream bits:
  - sn_a = (a > ctr_a)
  - sn_b = (b > ctr_b)
  - sn_mul = sn_a & sn_b
- Termination condition: term = (ctr_b == b) | (a == 0).
- On each rising edge with rst=0 and en=1:
  - If done=1: hold everything.
  - Else if term: set done←1; z, ctr_a and ctr_b hold.
  - Else: z←z+sn_mul and ctr_a←ctr_a+1. If ctr_a was all-ones, also ctr_b←ctr_b+1.
- ctr_b never exceeds b, so ctr_b never wraps. z never overflows, because the maximum is (2^WIDTH−1)^2.
- Result: after done, z = a·b exactly.
- Boundary cases:
  - a=0 or b=0: done sets on the first enabled cycle, z=0.
  - a=b=2^WIDTH−1: the full b·2^WIDTH run completes with no wrap.
- Changing a or b mid-operation is not supported; the result is undefined.

## Timing
- Reset (rst=1 at a rising edge, regardless of en) sets z=0, ov=0, ctr_a=0, ctr_b=0. Reset mid-operation aborts the operation; the next operation restarts from zero.
- Latency, in enabled cycles from the first enabled edge after reset:
  - a≠0 and b≠0: b·2^WIDTH accumulate cycles, plus 1 cycle to assert ov, for b·2^WIDTH+1 cycles total.
  - a=0 or b=0: 1 cycle.
- ov is registered. It rises on the edge after the last accumulation and stays high while en toggles, until rst.
- z is stable and equal to a·b whenever ov=1.
- en=0 cycles do not count toward latency. Deasserting en and then reasserting it resumes exactly where the operation stopped.
- No handshake beyond ov. The standard sequence is:
  1. Assert rst and apply new a, b.
  2. Release rst, then raise en.
  3. Wait for ov, then read z.

## Test plan
- a=15, b=15: ov rises after 15·256+1=3841 enabled cycles; z=225.
- a=0, b=37, and separately a=200, b=0: ov rises after 1 enabled cycle; z=0.
- a=255, b=255: ov rises after 65281 enabled cycles; z=65025; no counter wrap.
- a=100, b=3 with en dropped for 50 cycles mid-run: z and ov are frozen during the gap; final z=300 after 769 enabled cycles.
- rst asserted at cycle 500 of an a=255, b=10 run: z=0 and ov=0 on the next edge. Rerun with a=7, b=9: z=63 after 2305 cycles.
- 10 random back-to-back operations, each with the rst / en sequence: z=a·b every time, and ov stays low until each completes.
